jtexterm_comm_arb: RTL and testbench

- Parametrised successor to the main/sub shared communication RAM. Replaces the first-come-first-served dual-port RAM with a single-port RAM and real bus contention.
- Two CPU ports, main and sub, share one inferred RAM. Simultaneous accesses are arbitrated round-robin. A per-port ok/wait handshake drives the CPU wait logic.
- Sits between the main CPU decoder (ram_cs) and the sub/sound CPU bus.

---
 rtl/jtexterm_comm_arb.sv | 130 +++++++++++++
 tb/tb_jtexterm_comm_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/jtexterm_comm_arb.sv
// Round-robin arbiter letting the main and sub CPUs share one single-port RAM, with a per-port ok/wait handshake.
// Optional mailbox interrupts are enabled by defining JTEXTERM_MAILBOX_EN.
module jtexterm_comm_arb #(
    parameter int            AW        = 12,
    parameter int            DW        = 8,
    parameter logic [AW-1:0] MBOX_MAIN = {AW{1'b1}},
    parameter logic [AW-1:0] MBOX_SUB  = {AW{1'b1}} - 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          main_cs,
    input  logic          main_we,
    input  logic [AW-1:0] main_addr,
    input  logic [DW-1:0] main_din,
    output logic [DW-1:0] main_dout,
    output logic          main_ok,
    input  logic          sub_cs,
    input  logic          sub_we,
    input  logic [AW-1:0] sub_addr,
    input  logic [DW-1:0] sub_din,
    output logic [DW-1:0] sub_dout,
    output logic          sub_ok,
    output logic          main_irq_n,
    output logic          sub_irq_n
);

    typedef enum logic {GNT_MAIN = 1'b0, GNT_SUB = 1'b1} port_e;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          main_served_q, main_served_d;
    logic          sub_served_q,  sub_served_d;
    logic          main_ok_q,     main_ok_d;
    logic          sub_ok_q,      sub_ok_d;
    logic [DW-1:0] main_dout_q,   main_dout_d;
    logic [DW-1:0] sub_dout_q,    sub_dout_d;
    port_e         last_grant_q,  last_grant_d;

    logic          main_pend, sub_pend;
    logic          gnt_main, gnt_sub;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat, ram_rdat;
    logic          ram_we;

    always_comb begin
        main_pend = main_cs & ~main_served_q;
        sub_pend  = sub_cs  & ~sub_served_q;
        gnt_main  = main_pend & (~sub_pend | (last_grant_q == GNT_SUB));
        gnt_sub   = sub_pend & ~gnt_main;

        ram_addr  = gnt_sub ? sub_addr : main_addr;
        ram_wdat  = gnt_sub ? sub_din  : main_din;
        // Reset aborts the access, so no write may land while rst_n is low.
        ram_we    = rst_n & ((gnt_main & main_we) | (gnt_sub & sub_we));
        ram_rdat  = mem[ram_addr];

        main_served_d = main_cs & (main_served_q | gnt_main);
        sub_served_d  = sub_cs  & (sub_served_q  | gnt_sub);
        main_ok_d     = main_cs & (main_ok_q | gnt_main);
        sub_ok_d      = sub_cs  & (sub_ok_q  | gnt_sub);

        main_dout_d = (gnt_main & ~main_we) ? ram_rdat : main_dout_q;
        sub_dout_d  = (gnt_sub  & ~sub_we)  ? ram_rdat : sub_dout_q;

        last_grant_d = last_grant_q;
        if (gnt_main)     last_grant_d = GNT_MAIN;
        else if (gnt_sub) last_grant_d = GNT_SUB;
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_served_q <= 1'b0;
            sub_served_q  <= 1'b0;
            main_ok_q     <= 1'b0;
            sub_ok_q      <= 1'b0;
            main_dout_q   <= '0;
            sub_dout_q    <= '0;
            last_grant_q  <= GNT_SUB;
        end else begin
            main_served_q <= main_served_d;
            sub_served_q  <= sub_served_d;
            main_ok_q     <= main_ok_d;
            sub_ok_q      <= sub_ok_d;
            main_dout_q   <= main_dout_d;
            sub_dout_q    <= sub_dout_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign main_ok   = main_ok_q;
    assign sub_ok    = sub_ok_q;
    assign main_dout = main_dout_q;
    assign sub_dout  = sub_dout_q;

`ifdef JTEXTERM_MAILBOX_EN
    logic main_irq_n_q, main_irq_n_d;
    logic sub_irq_n_q,  sub_irq_n_d;

    // Writer raises the peer's interrupt; the peer's read of the same word acknowledges it.
    always_comb begin
        sub_irq_n_d  = sub_irq_n_q;
        main_irq_n_d = main_irq_n_q;
        if (gnt_main &  main_we && main_addr == MBOX_MAIN) sub_irq_n_d  = 1'b0;
        if (gnt_sub  & ~sub_we  && sub_addr  == MBOX_MAIN) sub_irq_n_d  = 1'b1;
        if (gnt_sub  &  sub_we  && sub_addr  == MBOX_SUB)  main_irq_n_d = 1'b0;
        if (gnt_main & ~main_we && main_addr == MBOX_SUB)  main_irq_n_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_irq_n_q <= 1'b1;
            sub_irq_n_q  <= 1'b1;
        end else begin
            main_irq_n_q <= main_irq_n_d;
            sub_irq_n_q  <= sub_irq_n_d;
        end
    end

    assign main_irq_n = main_irq_n_q;
    assign sub_irq_n  = sub_irq_n_q;
`else
    assign main_irq_n = 1'b1;
    assign sub_irq_n  = 1'b1;
`endif

endmodule

// File: tb/tb_jtexterm_comm_arb.sv
// Table-driven bench for jtexterm_comm_arb; expected outputs are queued per driven cycle and popped after the clock edge.
module tb_jtexterm_comm_arb;

`ifdef JTEXTERM_MAILBOX_EN
    localparam bit MB = 1'b1;
`else
    localparam bit MB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        main_cs = 0, main_we = 0, sub_cs = 0, sub_we = 0;
    logic [11:0] main_addr = '0, sub_addr = '0;
    logic [7:0]  main_din = '0, sub_din = '0;
    logic [7:0]  main_dout, sub_dout;
    logic        main_ok, sub_ok, main_irq_n, sub_irq_n;

    jtexterm_comm_arb dut (
        .clk(clk), .rst_n(rst_n),
        .main_cs(main_cs), .main_we(main_we), .main_addr(main_addr), .main_din(main_din),
        .main_dout(main_dout), .main_ok(main_ok),
        .sub_cs(sub_cs), .sub_we(sub_we), .sub_addr(sub_addr), .sub_din(sub_din),
        .sub_dout(sub_dout), .sub_ok(sub_ok),
        .main_irq_n(main_irq_n), .sub_irq_n(sub_irq_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mcs, mwe;
        logic [11:0] ma;
        logic [7:0]  mdi;
        logic        scs, swe;
        logic [11:0] sa;
        logic [7:0]  sdi;
        logic        emok, esok;
        logic [7:0]  emd, esd;
        logic        emirq, esirq;
    } vec_t;

    typedef struct {
        int         row;
        logic       mok, sok;
        logic [7:0] md, sd;
        logic       mirq, sirq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic mcs, input logic mwe, input logic [11:0] ma,
                       input logic [7:0] mdi, input logic scs, input logic swe, input logic [11:0] sa,
                       input logic [7:0] sdi, input logic emok, input logic esok, input logic [7:0] emd,
                       input logic [7:0] esd, input logic emirq, input logic esirq);
        vec_t v;
        v.rst = rst; v.mcs = mcs; v.mwe = mwe; v.ma = ma; v.mdi = mdi;
        v.scs = scs; v.swe = swe; v.sa = sa; v.sdi = sdi;
        v.emok = emok; v.esok = esok; v.emd = emd; v.esd = esd;
        v.emirq = MB ? emirq : 1'b1;
        v.esirq = MB ? esirq : 1'b1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic compare_outputs(input exp_t e);
        chk("main_ok",    e.row, {7'd0, main_ok},    {7'd0, e.mok});
        chk("sub_ok",     e.row, {7'd0, sub_ok},     {7'd0, e.sok});
        chk("main_dout",  e.row, main_dout,          e.md);
        chk("sub_dout",   e.row, sub_dout,           e.sd);
        chk("main_irq_n", e.row, {7'd0, main_irq_n}, {7'd0, e.mirq});
        chk("sub_irq_n",  e.row, {7'd0, sub_irq_n},  {7'd0, e.sirq});
    endtask

    initial begin
        exp_t e;
        // rst  main: cs we addr   din    sub: cs we addr   din    exp: mok sok md     sd     mirq sirq
        add(1, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h00, 1,1); // reset
        add(0, 1,1,12'h010,8'hA5, 0,0,12'h000,8'h00, 1,0,8'h00,8'h00, 1,1); // uncontended write
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h00, 1,1);
        add(0, 1,0,12'h010,8'h00, 0,0,12'h000,8'h00, 1,0,8'hA5,8'h00, 1,1); // uncontended read
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'hA5,8'h00, 1,1);
        add(0, 0,0,12'h000,8'h00, 1,1,12'h030,8'h3C, 0,1,8'hA5,8'h00, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'hA5,8'h00, 1,1);
        add(0, 1,1,12'h020,8'h11, 0,0,12'h000,8'h00, 1,0,8'hA5,8'h00, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'hA5,8'h00, 1,1);
        add(1, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h00, 1,1); // reset: main wins next tie
        add(0, 1,0,12'h010,8'h00, 1,0,12'h030,8'h00, 1,0,8'hA5,8'h00, 1,1);
        add(0, 1,0,12'h010,8'h00, 1,0,12'h030,8'h00, 1,1,8'hA5,8'h3C, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'hA5,8'h3C, 1,1);
        add(0, 1,0,12'h020,8'h00, 0,0,12'h000,8'h00, 1,0,8'h11,8'h3C, 1,1); // main last: sub wins next tie
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h11,8'h3C, 1,1);
        add(0, 1,0,12'h030,8'h00, 1,0,12'h020,8'h00, 0,1,8'h11,8'h11, 1,1);
        add(0, 1,0,12'h030,8'h00, 1,0,12'h020,8'h00, 1,1,8'h3C,8'h11, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h3C,8'h11, 1,1);
        add(1, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h00, 1,1); // reset before race
        add(0, 1,1,12'h020,8'h22, 1,0,12'h020,8'h00, 1,0,8'h00,8'h00, 1,1); // write wins, read sees new
        add(0, 1,1,12'h020,8'h22, 1,0,12'h020,8'h00, 1,1,8'h00,8'h22, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h22, 1,1);
        add(0, 1,0,12'h020,8'h00, 1,1,12'h020,8'h33, 1,0,8'h22,8'h22, 1,1); // read wins, sees old
        add(0, 1,0,12'h020,8'h00, 1,1,12'h020,8'h33, 1,1,8'h22,8'h22, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h22,8'h22, 1,1);
        add(0, 0,0,12'h000,8'h00, 1,1,12'h040,8'h77, 0,1,8'h22,8'h22, 1,1); // held sub write
        add(0, 1,1,12'h040,8'h55, 1,1,12'h040,8'h99, 1,1,8'h22,8'h22, 1,1);
        for (int i = 0; i < 8; i++)
            add(0, 0,0,12'h000,8'h00, 1,1,12'h040,8'h99, 0,1,8'h22,8'h22, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h22,8'h22, 1,1);
        add(0, 0,0,12'h000,8'h00, 1,0,12'h040,8'h00, 0,1,8'h22,8'h55, 1,1); // main overwrite survives
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h22,8'h55, 1,1);
        add(1, 0,0,12'h000,8'h00, 1,0,12'h040,8'h00, 0,0,8'h00,8'h00, 1,1); // reset as sub_cs rises
        add(0, 0,0,12'h000,8'h00, 1,0,12'h040,8'h00, 0,1,8'h00,8'h55, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h55, 1,1);
        add(0, 1,1,12'hFFF,8'h5A, 0,0,12'h000,8'h00, 1,0,8'h00,8'h55, 1,0); // mailbox to sub
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h55, 1,0);
        add(0, 0,0,12'h000,8'h00, 1,0,12'hFFF,8'h00, 0,1,8'h00,8'h5A, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h00,8'h5A, 1,1);
        add(0, 0,0,12'h000,8'h00, 1,1,12'hFFE,8'h66, 0,1,8'h00,8'h5A, 0,1); // mailbox to main
        add(0, 1,0,12'hFFE,8'h00, 0,0,12'h000,8'h00, 1,0,8'h66,8'h5A, 1,1);
        add(0, 0,0,12'h000,8'h00, 0,0,12'h000,8'h00, 0,0,8'h66,8'h5A, 1,1);

        @(negedge clk);
        chk("reset main_ok",    -1, {7'd0, main_ok},    8'd0);
        chk("reset sub_ok",     -1, {7'd0, sub_ok},     8'd0);
        chk("reset main_dout",  -1, main_dout,          8'd0);
        chk("reset sub_dout",   -1, sub_dout,           8'd0);
        chk("reset main_irq_n", -1, {7'd0, main_irq_n}, 8'd1);
        chk("reset sub_irq_n",  -1, {7'd0, sub_irq_n},  8'd1);

        foreach (vecs[i]) begin
            rst_n     = ~vecs[i].rst;
            main_cs   = vecs[i].mcs;  main_we  = vecs[i].mwe;
            main_addr = vecs[i].ma;   main_din = vecs[i].mdi;
            sub_cs    = vecs[i].scs;  sub_we   = vecs[i].swe;
            sub_addr  = vecs[i].sa;   sub_din  = vecs[i].sdi;
            e.row  = i;
            e.mok  = vecs[i].emok;  e.sok  = vecs[i].esok;
            e.md   = vecs[i].emd;   e.sd   = vecs[i].esd;
            e.mirq = vecs[i].emirq; e.sirq = vecs[i].esirq;
            sb_q.push_back(e);
            @(posedge clk);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard row %0d: got empty queue expected one entry", i);
            end else begin
                compare_outputs(sb_q.pop_front());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
